// File: rtl/iir_wb_stream_master_if.sv
`default_nettype none
// ============================================================================
// Module      : iir_wb_stream_master_if
// Description : Stream-in, stream-out and Wishbone classic master signals
//               shared by iir_wb_stream_master and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface iir_wb_stream_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  // Sample input stream
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  // Filtered output stream
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  // Wishbone classic bus
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_we_o;
  logic                  wb_stb_o;
  logic                  wb_cyc_o;
  logic                  wb_ack_i;

  modport master (
    input  s_data, s_valid, m_ready, wb_dat_i, wb_ack_i,
    output s_ready, m_data, m_valid, wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output s_data, s_valid, m_ready, wb_dat_i, wb_ack_i,
    input  s_ready, m_data, m_valid, wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );
endinterface
`default_nettype wire

// File: rtl/iir_wb_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : iir_wb_stream_master
// Description : Wishbone classic master feeding a memory-mapped IIR filter
//               from a valid/ready sample stream. Each sample is written to
//               the X register, the filter is given SETTLE_CYCLES to settle,
//               the Y register is read and the result is offered downstream.
//               Optional macro IIR_WB_TIMEOUT_EN adds a per-cycle ack timeout
//               that aborts the sample and pulses err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_wb_stream_master #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 6,
  parameter int unsigned ADDR_X         = 'h3C,
  parameter int unsigned ADDR_Y         = 'h40,
  parameter int          SETTLE_CYCLES  = 4,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  iir_wb_stream_master_if.master bus,
  output logic                   busy,
  output logic                   err_o
);

  // Addresses are folded into the bus width (ADDR_Y aliases 0 at 6 bits)
  localparam logic [ADDR_WIDTH-1:0] c_addr_x = ADDR_WIDTH'(ADDR_X);
  localparam logic [ADDR_WIDTH-1:0] c_addr_y = ADDR_WIDTH'(ADDR_Y);
  // Settle counter only needs to hold SETTLE_CYCLES-1
  localparam int c_scw = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    SETTLE = 3'd2,
    RD_REQ = 3'd3,
    RD     = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t           r_state;
  logic [c_scw-1:0] r_settle;

`ifdef IIR_WB_TIMEOUT_EN
  localparam int c_tw = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT_CYCLES - 1);
  logic [c_tw-1:0] r_tmo;
`else
  assign err_o = 1'b0;
`endif

  // Sequencer: one write, settle wait, one read per sample; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_settle     <= '0;
      busy         <= 1'b0;
      bus.s_ready  <= 1'b1;
      bus.m_data   <= {DATA_WIDTH{1'b0}};
      bus.m_valid  <= 1'b0;
      bus.wb_adr_o <= '0;
      bus.wb_dat_o <= {DATA_WIDTH{1'b0}};
      bus.wb_we_o  <= 1'b0;
      bus.wb_stb_o <= 1'b0;
      bus.wb_cyc_o <= 1'b0;
`ifdef IIR_WB_TIMEOUT_EN
      r_tmo        <= '0;
      err_o        <= 1'b0;
`endif
    end else begin
`ifdef IIR_WB_TIMEOUT_EN
      err_o <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // s_ready is high in IDLE, so s_valid alone completes the handshake
          if (bus.s_valid) begin
            bus.wb_dat_o <= bus.s_data;
            bus.wb_adr_o <= c_addr_x;
            bus.wb_we_o  <= 1'b1;
            bus.wb_cyc_o <= 1'b1;
            bus.wb_stb_o <= 1'b1;
            bus.s_ready  <= 1'b0;
            busy         <= 1'b1;
`ifdef IIR_WB_TIMEOUT_EN
            r_tmo        <= '0;
`endif
            r_state      <= WR;
          end
        end
        WR: begin
          if (bus.wb_ack_i) begin
            bus.wb_cyc_o <= 1'b0;
            bus.wb_stb_o <= 1'b0;
            bus.wb_we_o  <= 1'b0;
            if (SETTLE_CYCLES == 0) begin
              r_state <= RD_REQ;
            end else begin
              r_settle <= c_scw'(SETTLE_CYCLES - 1);
              r_state  <= SETTLE;
            end
          end
`ifdef IIR_WB_TIMEOUT_EN
          else if (r_tmo == c_tmo_last) begin
            bus.wb_cyc_o <= 1'b0;
            bus.wb_stb_o <= 1'b0;
            bus.wb_we_o  <= 1'b0;
            bus.s_ready  <= 1'b1;
            busy         <= 1'b0;
            err_o        <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        SETTLE: begin
          if (r_settle == '0) begin
            r_state <= RD_REQ;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        RD_REQ: begin
          // Dedicated setup cycle keeps stb low at least one cycle after the write ack
          bus.wb_adr_o <= c_addr_y;
          bus.wb_we_o  <= 1'b0;
          bus.wb_cyc_o <= 1'b1;
          bus.wb_stb_o <= 1'b1;
`ifdef IIR_WB_TIMEOUT_EN
          r_tmo        <= '0;
`endif
          r_state      <= RD;
        end
        RD: begin
          if (bus.wb_ack_i) begin
            bus.m_data   <= bus.wb_dat_i;
            bus.m_valid  <= 1'b1;
            bus.wb_cyc_o <= 1'b0;
            bus.wb_stb_o <= 1'b0;
            r_state      <= OUT;
          end
`ifdef IIR_WB_TIMEOUT_EN
          else if (r_tmo == c_tmo_last) begin
            bus.wb_cyc_o <= 1'b0;
            bus.wb_stb_o <= 1'b0;
            bus.s_ready  <= 1'b1;
            busy         <= 1'b0;
            err_o        <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        OUT: begin
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            bus.s_ready <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
